// File: rtl/wasm_i2c_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wasm_i2c_slave_pkg
//  Description : Shared definitions for the I2C debug slave: FSM state
//                encoding, default device address and ACK/NACK bus levels.
//  Revision    : 1.0 - initial release
// ============================================================================
package wasm_i2c_slave_pkg;

    typedef logic [3:0] state_t;

    localparam state_t c_ST_IDLE      = 4'd0;
    localparam state_t c_ST_ADDR      = 4'd1;
    localparam state_t c_ST_ADDR_ACK  = 4'd2;
    localparam state_t c_ST_PTR       = 4'd3;
    localparam state_t c_ST_PTR_ACK   = 4'd4;
    localparam state_t c_ST_WDATA     = 4'd5;
    localparam state_t c_ST_WDATA_ACK = 4'd6;
    localparam state_t c_ST_RDATA     = 4'd7;
    localparam state_t c_ST_RDATA_ACK = 4'd8;
    localparam state_t c_ST_IGNORE    = 4'd9;

    localparam logic [6:0] c_DEV_ADDR_DFLT = 7'h6C;

    // Bus levels as seen on SDA during the 9th clock.
    localparam logic c_ACK  = 1'b0;
    localparam logic c_NACK = 1'b1;

    // States in which the slave holds SDA low to acknowledge a received byte.
    function automatic logic is_ack_state(input state_t st);
        return (st == c_ST_ADDR_ACK) || (st == c_ST_PTR_ACK) || (st == c_ST_WDATA_ACK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wasm_i2c_sync.sv
`default_nettype none
// ============================================================================
//  Module      : wasm_i2c_sync
//  Description : Brings SCL/SDA into the i_clk domain and decodes SCL edges
//                plus START/STOP conditions from the synchronised samples.
//  Ports       : i_clk, i_rst_n (sync, active-low), i_scl, i_sda (async bus)
//                o_sda_lvl    synchronised SDA level
//                o_scl_rise   one-cycle pulse on SCL rising edge
//                o_scl_fall   one-cycle pulse on SCL falling edge
//                o_start      one-cycle pulse: SDA fell while SCL high
//                o_stop       one-cycle pulse: SDA rose while SCL high
//  Revision    : 1.0 - initial release
// ============================================================================
module wasm_i2c_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda_lvl,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Preset to 1 (idle bus) so leaving reset never fakes a START/STOP.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync[0] <= i_scl;
            r_sda_sync[0] <= i_sda;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_scl_sync[i] <= r_scl_sync[i-1];
                r_sda_sync[i] <= r_sda_sync[i-1];
            end
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_sda = r_sda_sync[SYNC_STAGES-1];

    assign o_sda_lvl  = w_sda;
    assign o_scl_rise =  w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl &  r_scl_prev;
    // SCL must be high on both samples so an SCL edge is never mistaken
    // for a bus condition.
    assign o_start    = w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
    assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev &  w_sda;

endmodule
`default_nettype wire

// File: rtl/wasm_i2c_slave.sv
`default_nettype none
// ============================================================================
//  Module      : wasm_i2c_slave
//  Description : I2C slave giving bus access to a debug register file.
//                Write: [addr/W][pointer][data...]  (pointer auto-increments)
//                Read : [addr/R][data...]           from the current pointer
//  Ports       : i_clk, i_rst_n (sync, active-low)
//                i_scl, i_sda       bus inputs, asynchronous to i_clk
//                o_sda              open-drain enable (0 = pull low)
//                i_debug_ena        0 keeps the slave off the bus
//                o_reg_addr         register pointer
//                i_reg_rd_data      register contents, 1 cycle after o_reg_addr
//                o_reg_wr_vld       one-cycle write strobe
//                o_reg_wr_data      write data qualified by o_reg_wr_vld
//  Revision    : 1.0 - initial release
// ============================================================================
module wasm_i2c_slave
    import wasm_i2c_slave_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = c_DEV_ADDR_DFLT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    input  logic       i_debug_ena,
    output logic [7:0] o_reg_addr,
    input  logic [7:0] i_reg_rd_data,
    output logic       o_reg_wr_vld,
    output logic [7:0] o_reg_wr_data
);

    logic       w_sda;
    logic       w_rise;
    logic       w_fall;
    logic       w_start;
    logic       w_stop;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_rw;
    logic [7:0] r_reg_addr;
    logic       r_wr_vld;
    logic [7:0] r_wr_data;
    logic       w_sda_drive;
    logic       w_byte_done;

    wasm_i2c_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda_lvl  (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    // A byte is complete on the SCL fall that follows its 8th rising edge.
    assign w_byte_done = w_fall && (r_bit_cnt == 4'd8);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. STOP beats START beats everything else.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = c_ST_IDLE;
        end else if (w_start) begin
            w_state_next = c_ST_ADDR;
        end else if (!i_debug_ena && (r_state != c_ST_IDLE) && (r_state != c_ST_IGNORE)) begin
            w_state_next = c_ST_IGNORE;
        end else begin
            case (r_state)
                c_ST_ADDR: begin
                    if (w_byte_done) begin
                        w_state_next = (r_shift[7:1] == DEV_ADDR) ? c_ST_ADDR_ACK : c_ST_IGNORE;
                    end
                end
                c_ST_ADDR_ACK: begin
                    if (w_fall) begin
                        w_state_next = r_rw ? c_ST_RDATA : c_ST_PTR;
                    end
                end
                c_ST_PTR: begin
                    if (w_byte_done) w_state_next = c_ST_PTR_ACK;
                end
                c_ST_PTR_ACK: begin
                    if (w_fall) w_state_next = c_ST_WDATA;
                end
                c_ST_WDATA: begin
                    if (w_byte_done) w_state_next = c_ST_WDATA_ACK;
                end
                c_ST_WDATA_ACK: begin
                    if (w_fall) w_state_next = c_ST_WDATA;
                end
                c_ST_RDATA: begin
                    if (w_byte_done) w_state_next = c_ST_RDATA_ACK;
                end
                c_ST_RDATA_ACK: begin
                    if (w_rise && (w_sda == c_NACK)) begin
                        w_state_next = c_ST_IGNORE;
                    end else if (w_fall && (r_bit_cnt == 4'd1)) begin
                        w_state_next = c_ST_RDATA;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic. SDA is decoded from registered state only, so it can
    // only move on the cycle after the fall that changed the state/shifter.
    // ------------------------------------------------------------------
    always_comb begin
        w_sda_drive = c_NACK;
        if (is_ack_state(r_state)) begin
            w_sda_drive = c_ACK;
        end else if (r_state == c_ST_RDATA) begin
            w_sda_drive = r_shift[7];
        end
    end

    // Disabling debug releases the bus immediately regardless of state.
    assign o_sda = w_sda_drive | ~i_debug_ena;

    // ------------------------------------------------------------------
    // Bit counter, shifter, pointer and write strobe
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'd0;
            r_rw       <= 1'b0;
            r_reg_addr <= 8'd0;
            r_wr_vld   <= 1'b0;
            r_wr_data  <= 8'd0;
        end else begin
            r_wr_vld <= 1'b0;
            if (w_stop || w_start) begin
                r_bit_cnt <= 4'd0;
            end else begin
                case (r_state)
                    c_ST_ADDR, c_ST_PTR, c_ST_WDATA: begin
                        if (w_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if ((r_state == c_ST_WDATA) && (r_bit_cnt == 4'd7) && i_debug_ena) begin
                                r_wr_vld  <= 1'b1;
                                r_wr_data <= {r_shift[6:0], w_sda};
                            end
                        end else if (w_byte_done) begin
                            r_bit_cnt <= 4'd0;
                            if (r_state == c_ST_ADDR) begin
                                r_rw <= r_shift[0];
                            end
                            if ((r_state == c_ST_PTR) && i_debug_ena) begin
                                r_reg_addr <= r_shift;
                            end
                        end
                    end
                    c_ST_ADDR_ACK, c_ST_PTR_ACK: begin
                        if (w_fall) begin
                            r_bit_cnt <= 4'd0;
                            // Read: first byte comes from the current pointer.
                            if ((r_state == c_ST_ADDR_ACK) && r_rw) begin
                                r_shift <= i_reg_rd_data;
                            end
                        end
                    end
                    c_ST_WDATA_ACK: begin
                        if (w_fall) begin
                            r_bit_cnt  <= 4'd0;
                            r_reg_addr <= r_reg_addr + 8'd1;
                        end
                    end
                    c_ST_RDATA: begin
                        if (w_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_byte_done) begin
                            r_bit_cnt <= 4'd0;
                        end else if (w_fall) begin
                            r_shift <= {r_shift[6:0], 1'b0};
                        end
                    end
                    c_ST_RDATA_ACK: begin
                        // bit_cnt==1 marks "master ACKed, reload on next fall".
                        // Pointer moves at the ACK rise so the register read
                        // has settled well before the reload.
                        if (w_rise && (w_sda == c_ACK)) begin
                            r_reg_addr <= r_reg_addr + 8'd1;
                            r_bit_cnt  <= 4'd1;
                        end else if (w_fall && (r_bit_cnt == 4'd1)) begin
                            r_shift   <= i_reg_rd_data;
                            r_bit_cnt <= 4'd0;
                        end
                    end
                    default: begin
                        r_bit_cnt <= r_bit_cnt;
                    end
                endcase
            end
        end
    end

    assign o_reg_addr    = r_reg_addr;
    assign o_reg_wr_vld  = r_wr_vld;
    assign o_reg_wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_wasm_i2c_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wasm_i2c_slave
//  Description : Directed testbench for wasm_i2c_slave. Acts as I2C master
//                on a wired-AND SDA and as a read-only register file whose
//                contents are reg[a] = a*7+3 (mod 256).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wasm_i2c_slave;

    localparam int c_Q = 6;   // quarter of an SCL bit, in clk cycles

    logic       clk;
    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    logic       o_sda;
    logic       bus_sda;
    logic       debug_ena;
    logic [7:0] reg_addr;
    logic [7:0] rd_data;
    logic       wr_vld;
    logic [7:0] wr_data;

    int         compared;
    int         mismatched;
    int         wr_cnt;
    logic [7:0] wr_data_seen;
    logic [7:0] wr_addr_seen;
    logic       low_seen;

    assign bus_sda = sda_m & o_sda;

    wasm_i2c_slave dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_scl         (scl_m),
        .i_sda         (bus_sda),
        .o_sda         (o_sda),
        .i_debug_ena   (debug_ena),
        .o_reg_addr    (reg_addr),
        .i_reg_rd_data (rd_data),
        .o_reg_wr_vld  (wr_vld),
        .o_reg_wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] reg_val(input logic [7:0] a);
        return a * 8'd7 + 8'd3;
    endfunction

    always @(posedge clk) rd_data <= reg_val(reg_addr);

    always @(negedge clk) begin
        if (o_sda === 1'b0) low_seen = 1'b1;
        if (wr_vld === 1'b1) begin
            wr_cnt       = wr_cnt + 1;
            wr_data_seen = wr_data;
            wr_addr_seen = reg_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- bus primitives ----------------
    task automatic wait_q(input int n);
        repeat (n * c_Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_q(1);
        sda_m = 1'b0; wait_q(1);
        scl_m = 1'b0; wait_q(1);
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wait_q(1);
        scl_m = 1'b1; wait_q(1);
        sda_m = 1'b0; wait_q(1);
        scl_m = 1'b0; wait_q(1);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q(1);
        scl_m = 1'b1; wait_q(1);
        sda_m = 1'b1; wait_q(1);
    endtask

    task automatic write_bit(input logic b);
        wait_q(1);
        sda_m = b; wait_q(1);
        scl_m = 1'b1; wait_q(2);
        scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q(2);
        scl_m = 1'b1; wait_q(1);
        b = bus_sda; wait_q(1);
        scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(ack);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; debug_ena = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++; if (o_sda !== 1'b1) begin mismatched++; $display("FAIL reset_sda: got %b want 1", o_sda); end
        compared++; if (reg_addr !== 8'h00) begin mismatched++; $display("FAIL reset_addr: got %h want 00", reg_addr); end
        compared++; if (wr_vld !== 1'b0) begin mismatched++; $display("FAIL reset_wr_vld: got %b want 0", wr_vld); end
        compared++; if (wr_data !== 8'h00) begin mismatched++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        wr_cnt = 0;
        i2c_start();
        write_byte(8'hD8, a0);
        write_byte(8'h02, a1);
        write_byte(8'hA5, a2);
        i2c_stop();
        wait_q(1);
        compared++; if (a0 !== 1'b0) begin mismatched++; $display("FAIL wr_ack_addr: got %b want 0", a0); end
        compared++; if (a1 !== 1'b0) begin mismatched++; $display("FAIL wr_ack_ptr: got %b want 0", a1); end
        compared++; if (a2 !== 1'b0) begin mismatched++; $display("FAIL wr_ack_data: got %b want 0", a2); end
        compared++; if (wr_cnt !== 1) begin mismatched++; $display("FAIL wr_strobe_cnt: got %0d want 1", wr_cnt); end
        compared++; if (wr_data_seen !== 8'hA5) begin mismatched++; $display("FAIL wr_data: got %h want a5", wr_data_seen); end
        compared++; if (wr_addr_seen !== 8'h02) begin mismatched++; $display("FAIL wr_addr: got %h want 02", wr_addr_seen); end
        compared++; if (reg_addr !== 8'h03) begin mismatched++; $display("FAIL wr_addr_after: got %h want 03", reg_addr); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1, d2;
        wr_cnt = 0;
        i2c_start();
        write_byte(8'hD8, a0);
        write_byte(8'h02, a1);
        i2c_rstart();
        write_byte(8'hD9, a2);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b0);
        read_byte(d2, 1'b1);
        i2c_stop();
        wait_q(1);
        compared++; if ({a0, a1, a2} !== 3'b000) begin mismatched++; $display("FAIL rd_acks: got %b want 000", {a0, a1, a2}); end
        compared++; if (d0 !== 8'h11) begin mismatched++; $display("FAIL rd_byte0: got %h want 11", d0); end
        compared++; if (d1 !== 8'h18) begin mismatched++; $display("FAIL rd_byte1: got %h want 18", d1); end
        compared++; if (d2 !== 8'h1F) begin mismatched++; $display("FAIL rd_byte2: got %h want 1f", d2); end
        compared++; if (reg_addr !== 8'h04) begin mismatched++; $display("FAIL rd_addr_after: got %h want 04", reg_addr); end
        compared++; if (o_sda !== 1'b1) begin mismatched++; $display("FAIL rd_idle_sda: got %b want 1", o_sda); end
        compared++; if (wr_cnt !== 0) begin mismatched++; $display("FAIL rd_no_strobe: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_bad_addr();
        logic a0, a1;
        wr_cnt = 0; low_seen = 1'b0;
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h33, a1);
        i2c_stop();
        wait_q(1);
        compared++; if ({a0, a1} !== 2'b11) begin mismatched++; $display("FAIL bad_addr_nack: got %b want 11", {a0, a1}); end
        compared++; if (low_seen !== 1'b0) begin mismatched++; $display("FAIL bad_addr_sda_low: got %b want 0", low_seen); end
        compared++; if (wr_cnt !== 0) begin mismatched++; $display("FAIL bad_addr_strobe: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_debug_off();
        logic a0, a1;
        wr_cnt = 0; low_seen = 1'b0;
        debug_ena = 1'b0;
        i2c_start();
        write_byte(8'hD8, a0);
        write_byte(8'h10, a1);
        i2c_stop();
        wait_q(1);
        debug_ena = 1'b1;
        compared++; if ({a0, a1} !== 2'b11) begin mismatched++; $display("FAIL dbg_off_nack: got %b want 11", {a0, a1}); end
        compared++; if (low_seen !== 1'b0) begin mismatched++; $display("FAIL dbg_off_sda_low: got %b want 0", low_seen); end
        compared++; if (wr_cnt !== 0) begin mismatched++; $display("FAIL dbg_off_strobe: got %0d want 0", wr_cnt); end
    endtask

    task automatic test_wrap();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        i2c_start();
        write_byte(8'hD8, a0);
        write_byte(8'hFF, a1);
        i2c_rstart();
        write_byte(8'hD9, a2);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        i2c_stop();
        wait_q(1);
        compared++; if ({a0, a1, a2} !== 3'b000) begin mismatched++; $display("FAIL wrap_acks: got %b want 000", {a0, a1, a2}); end
        compared++; if (d0 !== 8'hFC) begin mismatched++; $display("FAIL wrap_byte0: got %h want fc", d0); end
        compared++; if (d1 !== 8'h03) begin mismatched++; $display("FAIL wrap_byte1: got %h want 03", d1); end
        compared++; if (reg_addr !== 8'h00) begin mismatched++; $display("FAIL wrap_addr: got %h want 00", reg_addr); end
    endtask

    task automatic test_reset_mid();
        logic a0, a1, a2, b1, b2, b3, bit4;
        logic c0, c1, c2;
        // reg[0x01] = 0x0A: first four bits on the wire are 0,0,0,0
        i2c_start();
        write_byte(8'hD8, a0);
        write_byte(8'h01, a1);
        i2c_rstart();
        write_byte(8'hD9, a2);
        read_bit(b1);
        read_bit(b2);
        read_bit(b3);
        sda_m = 1'b1; wait_q(2);
        scl_m = 1'b1; wait_q(1);
        bit4 = bus_sda;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        compared++; if ({a0, a1, a2} !== 3'b000) begin mismatched++; $display("FAIL rstmid_acks: got %b want 000", {a0, a1, a2}); end
        compared++; if ({b1, b2, b3, bit4} !== 4'b0000) begin mismatched++; $display("FAIL rstmid_bits: got %b want 0000", {b1, b2, b3, bit4}); end
        compared++; if (o_sda !== 1'b1) begin mismatched++; $display("FAIL rstmid_sda: got %b want 1", o_sda); end
        compared++; if (reg_addr !== 8'h00) begin mismatched++; $display("FAIL rstmid_addr: got %h want 00", reg_addr); end
        wait_q(1);
        scl_m = 1'b0; wait_q(1);
        i2c_stop();
        wait_q(1);
        wr_cnt = 0;
        i2c_start();
        write_byte(8'hD8, c0);
        write_byte(8'h05, c1);
        write_byte(8'h77, c2);
        i2c_stop();
        wait_q(1);
        compared++; if ({c0, c1, c2} !== 3'b000) begin mismatched++; $display("FAIL rstmid_post_acks: got %b want 000", {c0, c1, c2}); end
        compared++; if (wr_cnt !== 1) begin mismatched++; $display("FAIL rstmid_post_cnt: got %0d want 1", wr_cnt); end
        compared++; if (wr_data_seen !== 8'h77) begin mismatched++; $display("FAIL rstmid_post_data: got %h want 77", wr_data_seen); end
        compared++; if (wr_addr_seen !== 8'h05) begin mismatched++; $display("FAIL rstmid_post_wraddr: got %h want 05", wr_addr_seen); end
        compared++; if (reg_addr !== 8'h06) begin mismatched++; $display("FAIL rstmid_post_addr: got %h want 06", reg_addr); end
    endtask

    initial begin
        compared = 0; mismatched = 0; wr_cnt = 0; low_seen = 1'b0;
        wr_data_seen = 8'h00; wr_addr_seen = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_bad_addr();
        test_debug_off();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
